// File: rtl/peripheral_msi_decoder.sv
// Wishbone slave-side decoder: routes the granted master cycle to one slave by address window,
// holding the selection for the whole cycle and answering unmapped or stalled accesses with an error.
module peripheral_msi_decoder #(
    parameter int                       NUM_SLAVES = 4,
    parameter int                       AW         = 32,
    parameter int                       DW         = 32,
    parameter logic [NUM_SLAVES*AW-1:0] MATCH_ADDR = '0,
    parameter logic [NUM_SLAVES*AW-1:0] MATCH_MASK = '0,
    parameter int                       TIMEOUT    = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [AW-1:0]            m_adr_i,
    input  logic [DW-1:0]            m_dat_i,
    input  logic [DW/8-1:0]          m_sel_i,
    input  logic                     m_we_i,
    input  logic                     m_cyc_i,
    input  logic                     m_stb_i,
    input  logic [2:0]               m_cti_i,
    input  logic [1:0]               m_bte_i,
    output logic [DW-1:0]            m_dat_o,
    output logic                     m_ack_o,
    output logic                     m_err_o,
    output logic                     m_rty_o,
    output logic [AW-1:0]            s_adr_o,
    output logic [DW-1:0]            s_dat_o,
    output logic [DW/8-1:0]          s_sel_o,
    output logic                     s_we_o,
    output logic [2:0]               s_cti_o,
    output logic [1:0]               s_bte_o,
    output logic [NUM_SLAVES-1:0]    s_cyc_o,
    output logic [NUM_SLAVES-1:0]    s_stb_o,
    input  logic [NUM_SLAVES*DW-1:0] s_dat_i,
    input  logic [NUM_SLAVES-1:0]    s_ack_i,
    input  logic [NUM_SLAVES-1:0]    s_err_i,
    input  logic [NUM_SLAVES-1:0]    s_rty_i
);

    localparam int         SW     = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [7:0] TO_LIM = 8'(TIMEOUT);
    localparam bit         TO_EN  = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        NOMATCH,
        WAIT_DROP
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [7:0]    cnt_q, cnt_d;

    logic          hit;
    logic [SW-1:0] hit_idx;
    logic          sel_ack, sel_err, sel_rty, sel_resp;
    logic [DW-1:0] sel_dat;
    logic          stall, to_fire;

    assign s_adr_o = m_adr_i;
    assign s_dat_o = m_dat_i;
    assign s_sel_o = m_sel_i;
    assign s_we_o  = m_we_i;
    assign s_cti_o = m_cti_i;
    assign s_bte_o = m_bte_i;

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((m_adr_i & MATCH_MASK[i*AW +: AW]) ==
                (MATCH_ADDR[i*AW +: AW] & MATCH_MASK[i*AW +: AW])) begin
                hit     = 1'b1;
                hit_idx = SW'(i);
            end
        end
    end

    assign sel_ack  = s_ack_i[sel_q];
    assign sel_err  = s_err_i[sel_q];
    assign sel_rty  = s_rty_i[sel_q];
    assign sel_dat  = s_dat_i[sel_q*DW +: DW];
    assign sel_resp = sel_ack | sel_err | sel_rty;

    // A response on the same cycle as the limit suppresses the timeout.
    assign stall   = (state_q == BUSY) && m_cyc_i && m_stb_i && !sel_resp;
    assign to_fire = TO_EN && stall && (cnt_q == TO_LIM - 8'd1);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = 8'd0;
        case (state_q)
            IDLE: begin
                if (m_cyc_i && m_stb_i) begin
                    if (hit) begin
                        sel_d   = hit_idx;
                        state_d = BUSY;
                    end else begin
                        state_d = NOMATCH;
                    end
                end
            end
            BUSY: begin
                if (!m_cyc_i) begin
                    state_d = IDLE;
                end else if (to_fire) begin
                    state_d = WAIT_DROP;
                end else if (stall && TO_EN) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            NOMATCH: state_d = WAIT_DROP;
            WAIT_DROP: begin
                if (!m_cyc_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_cyc_o = '0;
        s_stb_o = '0;
        m_dat_o = '0;
        m_ack_o = 1'b0;
        m_err_o = 1'b0;
        m_rty_o = 1'b0;
        case (state_q)
            BUSY: begin
                if (!to_fire) begin
                    s_cyc_o[sel_q] = m_cyc_i;
                    s_stb_o[sel_q] = m_stb_i;
                end
                m_dat_o = sel_dat;
                m_ack_o = sel_ack;
                m_err_o = sel_err | to_fire;
                m_rty_o = sel_rty;
            end
            NOMATCH: m_err_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: doc/peripheral_msi_decoder.md
Name: peripheral_msi_decoder

Overview:
- Slave-side companion to the Wishbone bus arbiter: takes the single granted master port and routes each bus cycle to one of NUM_SLAVES slave ports by address match.
- Latches the target slave at the start of each cycle and holds it until m_cyc_i drops, so bursts are never re-decoded.
- Returns a bus error for unmapped addresses and for slaves that fail to respond within TIMEOUT cycles.

Parameters:
NUM_SLAVES, 4, number of slave ports (>=2)
AW, 32, address width
DW, 32, data width
MATCH_ADDR, 0, packed NUM_SLAVES*AW base addresses; slave i occupies bits [i*AW +: AW]
MATCH_MASK, 0, packed NUM_SLAVES*AW masks; slave i matches when (m_adr_i & mask_i) == (addr_i & mask_i)
TIMEOUT, 255, response timeout in cycles, 8-bit counter range 1..255; 0 disables the watchdog

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
m_adr_i  in  AW  master address
m_dat_i  in  DW  master write data
m_sel_i  in  DW/8  byte selects
m_we_i  in  1  write enable
m_cyc_i  in  1  cycle valid
m_stb_i  in  1  strobe
m_cti_i  in  3  cycle type
m_bte_i  in  2  burst type
m_dat_o  out  DW  read data
m_ack_o  out  1  acknowledge
m_err_o  out  1  error
m_rty_o  out  1  retry
s_adr_o  out  AW  broadcast address
s_dat_o  out  DW  broadcast write data
s_sel_o  out  DW/8  broadcast byte selects
s_we_o  out  1  broadcast write enable
s_cti_o  out  3  broadcast cycle type
s_bte_o  out  2  broadcast burst type
s_cyc_o  out  NUM_SLAVES  per-slave cycle, one-hot or zero
s_stb_o  out  NUM_SLAVES  per-slave strobe, one-hot or zero
s_dat_i  in  NUM_SLAVES*DW  packed slave read data
s_ack_i  in  NUM_SLAVES  slave acks
s_err_i  in  NUM_SLAVES  slave errors
s_rty_i  in  NUM_SLAVES  slave retries

Behaviour:
- Reset is synchronous on clk: state=IDLE, selection=0, timeout counter=0. All of s_cyc_o, s_stb_o, m_ack_o, m_err_o and m_rty_o are 0 on the cycle after rst. m_dat_o is 0 whenever state is not BUSY.
- Reset asserted mid-transfer aborts the transfer. No response is issued, and slave strobes drop the cycle after reset.
- Broadcast signals (s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cti_o, s_bte_o) are combinational copies of the master signals.
- Address decode is combinational on m_adr_i. If several windows overlap, the lowest index wins.
- FSM states: IDLE, BUSY, NOMATCH, WAIT_DROP.
  - IDLE: on m_cyc_i & m_stb_i, register the matched index into selection and go to BUSY. With no match, go to NOMATCH. Slaves see no strobe in the decode cycle, so minimum latency is 1 cycle of decode plus the slave latency.
  - BUSY:
    - s_cyc_o[selection]=m_cyc_i and s_stb_o[selection]=m_stb_i; all other bits are 0.
    - m_dat_o, m_ack_o, m_err_o and m_rty_o are combinational from the selected slave.
    - Address changes inside the cycle are not re-decoded.
    - When m_cyc_i goes low, return to IDLE the same edge.
  - NOMATCH: m_err_o=1 for exactly one cycle, then go to WAIT_DROP. No slave strobe is asserted.
  - WAIT_DROP: all slave outputs and responses are 0. Return to IDLE when m_cyc_i=0. A master that holds cyc is never answered again.
- Watchdog, when TIMEOUT != 0:
  - In BUSY, the counter increments each cycle with m_stb_i=1 and no ack/err/rty from the selected slave.
  - The counter clears on any response, on stb low, and on leaving BUSY.
  - When the counter reaches TIMEOUT, m_err_o pulses for one cycle, s_cyc_o/s_stb_o drop on the same cycle, and state goes to WAIT_DROP.
  - If a slave response and the timeout coincide, the slave response wins and the counter clears.
- Simultaneous ack and err from the slave are passed through unchanged. The decoder does not arbitrate them.
- Back-to-back cycles: m_cyc_i low for one cycle, then high again, re-decodes normally from IDLE.

Test Plan:
- Default test parameters: NUM_SLAVES=4, masks FFFF0000, bases 0x1000_0000/0x2000_0000/0x3000_0000/0x4000_0000. Single read at 0x2000_0010 -> s_cyc_o=4'b0010 from cycle 1; slave 1 acks with 0xCAFEF00D after 2 cycles -> m_ack_o=1, m_dat_o=0xCAFEF00D; cyc drop -> IDLE, s_cyc_o=0.
- Same map, 4-beat incrementing burst (cti=010) starting at 0x3000_0000 with the address crossing into 0x4000_0000 on beat 3 -> all 4 beats go to slave 2, s_stb_o=4'b0100 throughout.
- Access to 0x5000_0000 -> exactly one m_err_o pulse, s_cyc_o=0 throughout; master holds cyc 5 more cycles -> no further responses; cyc drop then new access at 0x1000_0000 -> slave 0 selected.
- TIMEOUT=8, slave 3 never responds -> m_err_o on the 8th stalled strobe cycle, s_cyc_o[3] drops the same cycle; slave acks exactly at count 8 -> m_ack_o only, no err.
- Overlap test: slave 0 mask 0, slave 2 matches 0x3000_0000 -> slave 0 selected. Separately, rst asserted while BUSY with slave 1 -> next cycle all outputs 0, state IDLE.
